score_board: RTL

SCORE_BOARD -- requirements
Module: score_board

---
 rtl/score_pkg.sv | 23 ++
 rtl/bcd2_gt.sv | 14 +
 rtl/score_board.sv | 108 ++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the high-score table: FSM encoding, table geometry
// and the BCD digit clamp.
package score_pkg;

    localparam int TABLE_DEPTH = 4;
    localparam int BCD_W       = 4;
    localparam int IDX_W       = 2;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [2*BCD_W-1:0] entry_t;

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd2_gt.sv
// Two-digit BCD strict greater-than: {a_1,a_0} > {b_1,b_0}.
module bcd2_gt
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] a_1,
    input  logic [BCD_W-1:0] a_0,
    input  logic [BCD_W-1:0] b_1,
    input  logic [BCD_W-1:0] b_0,
    output logic             gt
);

    assign gt = (a_1 > b_1) || ((a_1 == b_1) && (a_0 > b_0));

endmodule

// File: rtl/score_board.sv
// Four-entry descending high-score table. A game-over edge captures the live score,
// scans for its slot one entry per cycle, then shifts it in.
module score_board
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BCD_W-1:0] score_0,
    input  logic [BCD_W-1:0] score_1,
    input  logic             slime_die,
    input  logic             clr_table,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [BCD_W-1:0] rd_score_0,
    output logic [BCD_W-1:0] rd_score_1,
    output logic [BCD_W-1:0] last_score_0,
    output logic [BCD_W-1:0] last_score_1,
    output logic [BCD_W-1:0] highest_score_0,
    output logic [BCD_W-1:0] highest_score_1,
    output logic             busy,
    output logic             new_record
);

    state_t           state;
    entry_t           tbl [TABLE_DEPTH];
    entry_t           pending;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ins;
    logic             die_q;
    logic             die_edge;
    logic             gt;

    assign die_edge = slime_die & ~die_q;

    bcd2_gt u_gt (
        .a_1 (pending[2*BCD_W-1:BCD_W]),
        .a_0 (pending[BCD_W-1:0]),
        .b_1 (tbl[idx][2*BCD_W-1:BCD_W]),
        .b_0 (tbl[idx][BCD_W-1:0]),
        .gt  (gt)
    );

    assign rd_score_1      = tbl[rd_idx][2*BCD_W-1:BCD_W];
    assign rd_score_0      = tbl[rd_idx][BCD_W-1:0];
    assign highest_score_1 = tbl[0][2*BCD_W-1:BCD_W];
    assign highest_score_0 = tbl[0][BCD_W-1:0];

    // die_q resets high so a level held through reset never looks like a fresh edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            for (int k = 0; k < TABLE_DEPTH; k++) tbl[k] <= '0;
            pending      <= '0;
            last_score_0 <= '0;
            last_score_1 <= '0;
            idx          <= '0;
            ins          <= '0;
            die_q        <= 1'b1;
            busy         <= 1'b0;
            new_record   <= 1'b0;
        end else begin
            die_q      <= slime_die;
            new_record <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_table) begin
                        for (int k = 0; k < TABLE_DEPTH; k++) tbl[k] <= '0;
                    end else if (die_edge) begin
                        pending      <= {clamp_digit(score_1), clamp_digit(score_0)};
                        last_score_1 <= clamp_digit(score_1);
                        last_score_0 <= clamp_digit(score_0);
                        idx          <= '0;
                        state        <= SCAN;
                        busy         <= 1'b1;
                    end
                end
                SCAN: begin
                    if (gt) begin
                        ins   <= idx;
                        state <= SHIFT;
                    end else if (idx == IDX_W'(TABLE_DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SHIFT: begin
                    // Entries below the slot move down one; the old last entry falls off
                    for (int k = 1; k < TABLE_DEPTH; k++) begin
                        if (IDX_W'(k) > ins) tbl[k] <= tbl[k-1];
                    end
                    tbl[ins]   <= pending;
                    new_record <= (ins == '0);
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
